// File: rtl/instr_bus_arbiter.sv
// Instruction-fetch bus arbiter: N masters onto one slave, with in-order response routing via an ID FIFO.
// Define INSTR_BUS_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority.
module instr_bus_arbiter #(
   parameter int NUM_MASTERS     = 2,
   parameter int ADDR_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_MASTERS-1:0]            m_req,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
   output logic [NUM_MASTERS-1:0]            m_gnt,
   output logic [NUM_MASTERS-1:0]            m_rvalid,
   output logic [31:0]                       m_rdata,
   output logic [6:0]                        m_rdata_intg,
   output logic                              m_err,
   output logic                              s_req,
   output logic [ADDR_WIDTH-1:0]             s_addr,
   input  logic                              s_gnt,
   input  logic                              s_rvalid,
   input  logic                              s_err,
   input  logic [31:0]                       s_rdata,
   input  logic [6:0]                        s_rdata_intg,
   output logic                              spurious_rsp
);

   localparam int IDW = $clog2(NUM_MASTERS);
   localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

   logic [CW-1:0]          count_r;
   logic [PW-1:0]          wr_ptr_r;
   logic [PW-1:0]          rd_ptr_r;
   logic [IDW-1:0]         fifo_r [MAX_OUTSTANDING];
   logic                   lock_r;
   logic [IDW-1:0]         lock_id_r;
   logic                   spurious_r;
   logic [IDW-1:0]         ptr_s;
   logic                   full_s;
   logic [NUM_MASTERS-1:0] eligible_s;
   logic                   found_s;
   logic [IDW-1:0]         arb_id_s;
   logic [IDW-1:0]         sel_s;
   logic                   hs_s;
   logic                   rsp_s;
   logic [IDW-1:0]         head_id_s;

   function automatic logic [PW-1:0] fifo_ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(MAX_OUTSTANDING - 1)) begin
         return {PW{1'b0}};
      end else begin
         return p + PW'(1);
      end
   endfunction

   function automatic logic [IDW-1:0] master_inc(input logic [IDW-1:0] id);
      if (id == IDW'(NUM_MASTERS - 1)) begin
         return {IDW{1'b0}};
      end else begin
         return id + IDW'(1);
      end
   endfunction

   assign full_s     = (count_r == CW'(MAX_OUTSTANDING));
   assign eligible_s = full_s ? {NUM_MASTERS{1'b0}} : m_req;
   assign sel_s      = lock_r ? lock_id_r : arb_id_s;
   assign s_req      = ~rst & (lock_r | (|eligible_s));
   assign s_addr     = m_addr[sel_s*ADDR_WIDTH +: ADDR_WIDTH];
   assign hs_s       = s_req & s_gnt;
   assign rsp_s      = s_rvalid & (count_r != {CW{1'b0}});
   assign head_id_s  = fifo_r[rd_ptr_r];

   assign m_rdata      = s_rdata;
   assign m_rdata_intg = s_rdata_intg;
   assign m_err        = s_err;
   assign spurious_rsp = spurious_r;

`ifdef INSTR_BUS_ARB_ROUND_ROBIN_EN
   logic [IDW-1:0] rr_ptr_r;

   // Round-robin pointer: moves past the master that just completed a handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_r <= {IDW{1'b0}};
      end else if (hs_s) begin
         rr_ptr_r <= master_inc(sel_s);
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

   assign ptr_s = rr_ptr_r;
`else
   assign ptr_s = {IDW{1'b0}};
`endif

   // Search eligible masters starting at ptr_s; a zero start gives lowest-index priority.
   always_comb begin
      found_s  = 1'b0;
      arb_id_s = {IDW{1'b0}};
      for (int k = 0; k < NUM_MASTERS; k++) begin
         int idx_s;
         idx_s = int'(ptr_s) + k;
         if (idx_s >= NUM_MASTERS) begin
            idx_s = idx_s - NUM_MASTERS;
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && eligible_s[idx_s]) begin
            found_s  = 1'b1;
            arb_id_s = IDW'(idx_s);
         end else begin
            found_s  = found_s;
         end
      end
   end

   // Decode grant and response-routing one-hots.
   always_comb begin
      m_gnt    = {NUM_MASTERS{1'b0}};
      m_rvalid = {NUM_MASTERS{1'b0}};
      for (int i = 0; i < NUM_MASTERS; i++) begin
         m_gnt[i]    = hs_s & (sel_s == IDW'(i));
         m_rvalid[i] = rsp_s & (head_id_s == IDW'(i));
      end
   end

   // ID FIFO, outstanding count, address lock and spurious-response flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r    <= {CW{1'b0}};
         wr_ptr_r   <= {PW{1'b0}};
         rd_ptr_r   <= {PW{1'b0}};
         lock_r     <= 1'b0;
         lock_id_r  <= {IDW{1'b0}};
         spurious_r <= 1'b0;
         for (int j = 0; j < MAX_OUTSTANDING; j++) begin
            fifo_r[j] <= {IDW{1'b0}};
         end
      end else begin
         if (hs_s) begin
            fifo_r[wr_ptr_r] <= sel_s;
            wr_ptr_r         <= fifo_ptr_inc(wr_ptr_r);
         end else begin
            wr_ptr_r         <= wr_ptr_r;
         end
         if (rsp_s) begin
            rd_ptr_r <= fifo_ptr_inc(rd_ptr_r);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({hs_s, rsp_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
         // Hold the selection while the slave stalls so s_addr cannot change mid-request.
         if (s_req && !s_gnt) begin
            lock_r    <= 1'b1;
            lock_id_r <= sel_s;
         end else if (hs_s) begin
            lock_r    <= 1'b0;
            lock_id_r <= lock_id_r;
         end else begin
            lock_r    <= lock_r;
            lock_id_r <= lock_id_r;
         end
         if (s_rvalid && (count_r == {CW{1'b0}})) begin
            spurious_r <= 1'b1;
         end else begin
            spurious_r <= spurious_r;
         end
      end
   end

endmodule

// File: tb/tb_instr_bus_arbiter.sv
// Directed self-checking bench for instr_bus_arbiter (2 masters, 32-bit address, 2 outstanding).
module tb_instr_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  m_req;
   logic [63:0] m_addr;
   logic [1:0]  m_gnt;
   logic [1:0]  m_rvalid;
   logic [31:0] m_rdata;
   logic [6:0]  m_rdata_intg;
   logic        m_err;
   logic        s_req;
   logic [31:0] s_addr;
   logic        s_gnt;
   logic        s_rvalid;
   logic        s_err;
   logic [31:0] s_rdata;
   logic [6:0]  s_rdata_intg;
   logic        spurious_rsp;

   int n_checks = 0;
   int n_errors = 0;

   instr_bus_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
      .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_gnt(m_gnt),
      .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rdata_intg(m_rdata_intg), .m_err(m_err),
      .s_req(s_req), .s_addr(s_addr), .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err),
      .s_rdata(s_rdata), .s_rdata_intg(s_rdata_intg), .spurious_rsp(spurious_rsp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic to_next();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] exp_gnt;
      logic [1:0] prev_gnt;

      rst = 1'b1; m_req = 2'b11; m_addr = {32'h0000_2000, 32'h0000_1000};
      s_gnt = 1'b1; s_rvalid = 1'b0; s_err = 1'b0; s_rdata = 32'h0; s_rdata_intg = 7'h0;
      to_next();
      to_neg();
      check("rst_s_req", s_req, 1'b0);
      check("rst_m_gnt", m_gnt, 2'b00);
      check("rst_m_rvalid", m_rvalid, 2'b00);
      check("rst_spurious", spurious_rsp, 1'b0);
      to_next();
      rst = 1'b0;

      // Both masters requesting, slave always grants, response one cycle after each grant.
      prev_gnt = 2'b00;
      for (int c = 0; c < 4; c++) begin
         s_rvalid = (c > 0);
         s_rdata  = 32'hA500_0000 + c;
         s_err    = c[0];
`ifdef INSTR_BUS_ARB_ROUND_ROBIN_EN
         exp_gnt = c[0] ? 2'b10 : 2'b01;
`else
         exp_gnt = 2'b01;
`endif
         to_neg();
         check("stream_gnt", m_gnt, exp_gnt);
         check("stream_addr", s_addr, exp_gnt[1] ? 32'h0000_2000 : 32'h0000_1000);
         check("stream_rvalid", m_rvalid, prev_gnt);
         check("stream_rdata", m_rdata, 32'hA500_0000 + c);
         check("stream_err", m_err, c[0]);
         prev_gnt = exp_gnt;
         to_next();
      end
      m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b1;
      to_neg();
      check("drain_rvalid", m_rvalid, prev_gnt);
      check("drain_s_req", s_req, 1'b0);
      to_next();
      s_rvalid = 1'b0;

      // Stalled request from master 1 locks the address until the slave grants.
      m_req = 2'b10; m_addr = {32'h0000_0100, 32'h0000_0F00};
      for (int c = 0; c < 3; c++) begin
         to_neg();
         check("lock_s_req", s_req, 1'b1);
         check("lock_addr", s_addr, 32'h0000_0100);
         check("lock_gnt", m_gnt, 2'b00);
         to_next();
      end
      m_req = 2'b11;
      to_neg();
      check("lock_addr_both", s_addr, 32'h0000_0100);
      check("lock_gnt_both", m_gnt, 2'b00);
      to_next();
      s_gnt = 1'b1;
      to_neg();
      check("lock_first_gnt", m_gnt, 2'b10);
      check("lock_addr_gnt", s_addr, 32'h0000_0100);
      to_next();
      m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b1;
      to_neg();
      check("lock_rvalid", m_rvalid, 2'b10);
      to_next();
      s_rvalid = 1'b0;

      // Fill to MAX_OUTSTANDING and observe back-pressure.
      m_req = 2'b01; s_gnt = 1'b1;
      for (int c = 0; c < 2; c++) begin
         to_neg();
         check("fill_gnt", m_gnt, 2'b01);
         to_next();
      end
      to_neg();
      check("full_s_req", s_req, 1'b0);
      check("full_gnt", m_gnt, 2'b00);
      to_next();
      s_rvalid = 1'b1;
      to_neg();
      check("full_rsp_rvalid", m_rvalid, 2'b01);
      check("full_rsp_s_req", s_req, 1'b0);
      to_next();
      s_rvalid = 1'b0;
      to_neg();
      check("reopen_s_req", s_req, 1'b1);
      check("reopen_gnt", m_gnt, 2'b01);
      to_next();
      m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b1;
      for (int c = 0; c < 2; c++) begin
         to_neg();
         check("full_drain_rvalid", m_rvalid, 2'b01);
         to_next();
      end

      // Response with nothing outstanding.
      to_neg();
      check("spur_rvalid", m_rvalid, 2'b00);
      check("spur_before", spurious_rsp, 1'b0);
      to_next();
      s_rvalid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         to_neg();
         check("spur_sticky", spurious_rsp, 1'b1);
         to_next();
      end
      rst = 1'b1;
      to_neg();
      check("spur_cleared", spurious_rsp, 1'b0);
      to_next();
      rst = 1'b0;

      // Reset with two transactions in flight discards their IDs.
      m_req = 2'b01; s_gnt = 1'b1;
      to_next();
      to_next();
      m_req = 2'b00; s_gnt = 1'b0; rst = 1'b1;
      to_next();
      rst = 1'b0; s_rvalid = 1'b1;
      to_neg();
      check("post_rst_rvalid", m_rvalid, 2'b00);
      check("post_rst_spur_pre", spurious_rsp, 1'b0);
      to_next();
      s_rvalid = 1'b0;
      to_neg();
      check("post_rst_spur", spurious_rsp, 1'b1);
      to_next();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
